// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states and instruction word field positions.
package program_loader_pkg;

    localparam int R1SEL_BIT = 15;
    localparam int R0SEL_BIT = 14;
    localparam int OPC_MSB   = 13;
    localparam int OPC_LSB   = 8;
    localparam int DATA_MSB  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Opcode bits are carried verbatim; only field placement is fixed here.
    function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        w                  = '0;
        w[R1SEL_BIT]       = hi[7];
        w[R0SEL_BIT]       = hi[6];
        w[OPC_MSB:OPC_LSB] = hi[5:0];
        w[DATA_MSB:0]      = lo;
        return w;
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// 8-bit XOR accumulator; clear has priority over enable.
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] csum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'h00;
        end else if (clear) begin
            csum <= 8'h00;
        end else if (en) begin
            csum <= csum ^ din;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Assembles instruction words from a byte stream, writes them to program memory and
// holds the CPU in reset until a load passes its checksum.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready; byte_ready
// depends only on state, and byte_data is sampled only on a transfer.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int RW    = ADDR_W + 1;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     rem;
    logic [7:0]        hi_q, lo_q;
    logic [7:0]        csum;
    logic              csum_clr, csum_en;
    logic              count_ovf;

    assign count_ovf = int'(byte_data) > DEPTH;

    loader_checksum u_checksum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clr),
        .en    (csum_en),
        .din   (byte_data),
        .csum  (csum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        csum_clr   = 1'b0;
        csum_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    csum_clr   = 1'b1;
                    next_state = ST_COUNT;
                end
            end
            ST_COUNT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    csum_en = 1'b1;
                    if (byte_data == 8'h00) next_state = ST_CHECK;
                    else if (count_ovf)     next_state = ST_DONE;
                    else                    next_state = ST_HI;
                end
            end
            ST_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    csum_en    = 1'b1;
                    next_state = ST_LO;
                end
            end
            ST_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    csum_en    = 1'b1;
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we     = 1'b1;
                next_state = (rem == RW'(1)) ? ST_CHECK : ST_HI;
            end
            ST_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            rem      <= '0;
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            err      <= 1'b0;
            cpu_rstn <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr     <= '0;
                        err      <= 1'b0;
                        cpu_rstn <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (byte_valid) begin
                        rem <= RW'(byte_data);
                        if (count_ovf) err <= 1'b1;
                    end
                end
                ST_HI:    if (byte_valid) hi_q <= byte_data;
                ST_LO:    if (byte_valid) lo_q <= byte_data;
                ST_WRITE: begin
                    addr <= addr + ADDR_W'(1);
                    rem  <= rem - RW'(1);
                end
                ST_CHECK: if (byte_valid) err <= (byte_data != csum);
                ST_DONE:  cpu_rstn <= ~err;
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr;
    assign mem_wdata = pack_word(hi_q, lo_q);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed sessions plus randomized loads against a stream-level model.
module tb_program_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rstn   (cpu_rstn),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          passed = 0;
  int          total  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic [15:0] tb_mem [DEPTH];
  logic [15:0] words_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // program memory model and write checker
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] = mem_wdata;
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_e));
      end
    end
  end

  // driver tasks: entered and left at a falling edge
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n;
    if (rnd) begin
      int g;
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        start      = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", 32'(byte_ready), 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // words_q holds the payload; model: writes only if N fits, err if overflow or bad checksum
  task automatic run_session(input logic [7:0] n, input logic [7:0] chk, input bit rnd);
    bit         ovf;
    bit         exp_err;
    logic [7:0] x;
    ovf = int'(n) > DEPTH;
    x = n;
    foreach (words_q[i]) x = x ^ words_q[i][15:8] ^ words_q[i][7:0];
    exp_err = ovf || (chk != x);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_cpu_rstn", 32'(cpu_rstn), 0);
    check("start_err_clr", 32'(err), 0);

    if (!ovf)
      for (int i = 0; i < int'(n); i++) exp_q.push_back({ADDR_W'(i), words_q[i]});

    send_byte(n, rnd);
    if (!ovf) begin
      for (int i = 0; i < int'(n); i++) begin
        send_byte(words_q[i][15:8], rnd);
        send_byte(words_q[i][7:0], rnd);
        check("write_latency", 32'(mem_we), 1);
      end
      send_byte(chk, rnd);
    end
    check("done_pulse", 32'(done), 1);
    check("done_err", 32'(err), 32'(exp_err));
    check("all_writes_seen", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("cpu_rstn_after", 32'(cpu_rstn), 32'(!exp_err));
  endtask

  function automatic logic [7:0] good_chk(input logic [7:0] n);
    logic [7:0] x;
    x = n;
    foreach (words_q[i]) x = x ^ words_q[i][15:8] ^ words_q[i][7:0];
    return x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(byte_ready), 0);
    check({tag, "_we"},     32'(mem_we), 0);
    check({tag, "_addr"},   32'(mem_addr), 0);
    check({tag, "_wdata"},  32'(mem_wdata), 0);
    check({tag, "_rstn"},   32'(cpu_rstn), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_err"},    32'(err), 0);
  endtask

  initial begin
    logic [7:0] n;
    logic [7:0] chk;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    foreach (tb_mem[i]) tb_mem[i] = 16'h0000;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // two-word load, good checksum
    words_q = '{16'h4105, 16'h8207};
    run_session(8'h02, good_chk(8'h02), 1'b0);
    check("mem0_t1", 32'(tb_mem[0]), 32'h4105);
    check("mem1_t1", 32'(tb_mem[1]), 32'h8207);

    // same stream, bad checksum
    run_session(8'h02, 8'h00, 1'b0);

    // empty load
    words_q = {};
    run_session(8'h00, 8'h00, 1'b0);

    // count exceeds depth
    run_session(8'h05, 8'h00, 1'b0);

    // full-depth load ending at the top address
    words_q = '{16'h1111, 16'h2222, 16'h3333, 16'hC3FF};
    run_session(8'h04, good_chk(8'h04), 1'b0);
    check("mem_top", 32'(tb_mem[DEPTH-1]), 32'hC3FF);

    // first stream again with random valid gaps and stray start pulses
    words_q = '{16'h4105, 16'h8207};
    run_session(8'h02, good_chk(8'h02), 1'b1);

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      n = 8'($urandom_range(0, DEPTH + 1));
      if ($urandom_range(0, 9) == 0) n = 8'hFF;
      words_q = {};
      if (int'(n) <= DEPTH)
        for (int i = 0; i < int'(n); i++) words_q.push_back(16'($urandom));
      chk = good_chk(n);
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_session(n, chk, 1'b1);
    end

    // async reset while waiting for LO of word 1
    tb_mem[0] = 16'h0000;
    tb_mem[1] = 16'h0000;
    words_q = '{16'h4105, 16'h8207};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back({ADDR_W'(0), 16'h4105});
    send_byte(8'h02, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h82, 1'b0);
    check("pre_rst_state_lo", 32'(byte_ready), 1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q = {};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mem0_kept", 32'(tb_mem[0]), 32'h4105);
    check("mem1_unwritten", 32'(tb_mem[1]), 32'h0000);
    run_session(8'h02, good_chk(8'h02), 1'b0);
    check("mem1_after_reload", 32'(tb_mem[1]), 32'h8207);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
